// File: rtl/order_manager.sv
// order_manager: turns qualified buy/sell decisions and the live price stream
// into single-position market orders over a valid/ready handshake. It also
// tracks the position, runs a post-fill cooldown, fires a hard stop-loss and
// accumulates realized P&L.
module order_manager #(
  parameter logic [7:0]  QTY        = 8'd10,
  parameter int unsigned COOLDOWN   = 4,
  parameter logic [15:0] STOP_DELTA = 16'd200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] price_in,
  input  logic        new_price,
  input  logic        buy,
  input  logic        sell,
  input  logic        sig_valid,
  output logic        order_valid,
  input  logic        order_ready,
  output logic        order_side,
  output logic [15:0] order_price,
  output logic [7:0]  order_qty,
  output logic        long_pos,
  output logic [15:0] entry_price,
  output logic [31:0] realized_pnl,
  output logic [7:0]  trade_cnt,
  output logic        stop_hit
);

  localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN);

  typedef enum logic [1:0] {FLAT, PEND_BUY, LONG, PEND_SELL} state_t;

  state_t      state_q, state_d;
  logic [15:0] last_price_q, last_price_d;
  logic        price_seen_q, price_seen_d;
  logic [7:0]  cooldown_q, cooldown_d;
  logic        order_side_q, order_side_d;
  logic [15:0] order_price_q, order_price_d;
  logic [15:0] entry_price_q, entry_price_d;
  logic        long_pos_q, long_pos_d;
  logic [31:0] realized_pnl_q, realized_pnl_d;
  logic [7:0]  trade_cnt_q, trade_cnt_d;
  logic        stop_hit_q, stop_hit_d;

  logic [15:0]        cur_price;
  logic               fill;
  logic               sig_buy;
  logic               sig_sell;
  logic               stop_trig;
  logic signed [16:0] pnl_diff;
  logic signed [24:0] pnl_diff_ext;
  logic signed [24:0] qty_ext;
  logic signed [24:0] pnl_prod;

  assign order_valid  = (state_q == PEND_BUY) || (state_q == PEND_SELL);
  assign order_side   = order_side_q;
  assign order_price  = order_price_q;
  assign order_qty    = order_valid ? QTY : 8'd0;
  assign long_pos     = long_pos_q;
  assign entry_price  = entry_price_q;
  assign realized_pnl = realized_pnl_q;
  assign trade_cnt    = trade_cnt_q;
  assign stop_hit     = stop_hit_q;

  // Next-state logic: price tracking, cooldown, order FSM, fills and P&L.
  always_comb begin
    state_d        = state_q;
    last_price_d   = last_price_q;
    price_seen_d   = price_seen_q;
    cooldown_d     = cooldown_q;
    order_side_d   = order_side_q;
    order_price_d  = order_price_q;
    entry_price_d  = entry_price_q;
    long_pos_d     = long_pos_q;
    realized_pnl_d = realized_pnl_q;
    trade_cnt_d    = trade_cnt_q;
    stop_hit_d     = 1'b0;

    cur_price = new_price ? price_in : last_price_q;
    fill      = order_valid & order_ready;
    sig_buy   = sig_valid & buy & ~sell;
    sig_sell  = sig_valid & sell & ~buy;
    stop_trig = new_price &&
                (({1'b0, price_in} + {1'b0, STOP_DELTA}) < {1'b0, entry_price_q});

    pnl_diff     = $signed({1'b0, order_price_q}) - $signed({1'b0, entry_price_q});
    pnl_diff_ext = {{8{pnl_diff[16]}}, pnl_diff};
    qty_ext      = {17'd0, QTY};
    pnl_prod     = pnl_diff_ext * qty_ext;

    if (new_price) begin
      last_price_d = price_in;
      price_seen_d = 1'b1;
    end

    if (new_price && (cooldown_q != 8'd0)) begin
      cooldown_d = cooldown_q - 8'd1;
    end

    case (state_q)
      FLAT: begin
        if (sig_buy && (price_seen_q || new_price) && (cooldown_q == 8'd0)) begin
          state_d       = PEND_BUY;
          order_side_d  = 1'b0;
          order_price_d = cur_price;
        end
      end
      PEND_BUY: begin
        if (fill) begin
          state_d       = LONG;
          entry_price_d = order_price_q;
          long_pos_d    = 1'b1;
          trade_cnt_d   = trade_cnt_q + 8'd1;
          cooldown_d    = COOL_LOAD;
        end
      end
      LONG: begin
        if (stop_trig) begin
          state_d       = PEND_SELL;
          order_side_d  = 1'b1;
          order_price_d = price_in;
          stop_hit_d    = 1'b1;
        end else if (sig_sell && (cooldown_q == 8'd0)) begin
          state_d       = PEND_SELL;
          order_side_d  = 1'b1;
          order_price_d = cur_price;
        end
      end
      PEND_SELL: begin
        if (fill) begin
          state_d        = FLAT;
          long_pos_d     = 1'b0;
          realized_pnl_d = realized_pnl_q + {{7{pnl_prod[24]}}, pnl_prod};
          trade_cnt_d    = trade_cnt_q + 8'd1;
          cooldown_d     = COOL_LOAD;
        end
      end
      default: state_d = FLAT;
    endcase
  end

  // State registers; reset clears everything and drops any pending order at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= FLAT;
      last_price_q   <= 16'd0;
      price_seen_q   <= 1'b0;
      cooldown_q     <= 8'd0;
      order_side_q   <= 1'b0;
      order_price_q  <= 16'd0;
      entry_price_q  <= 16'd0;
      long_pos_q     <= 1'b0;
      realized_pnl_q <= 32'd0;
      trade_cnt_q    <= 8'd0;
      stop_hit_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_price_q   <= last_price_d;
      price_seen_q   <= price_seen_d;
      cooldown_q     <= cooldown_d;
      order_side_q   <= order_side_d;
      order_price_q  <= order_price_d;
      entry_price_q  <= entry_price_d;
      long_pos_q     <= long_pos_d;
      realized_pnl_q <= realized_pnl_d;
      trade_cnt_q    <= trade_cnt_d;
      stop_hit_q     <= stop_hit_d;
    end
  end

endmodule

// File: tb/tb_order_manager.sv
// tb_order_manager: scoreboard bench for order_manager. Expected orders are
// queued when the triggering stimulus is driven and checked when the DUT
// presents and fills them; state outputs are checked directly in between.
module tb_order_manager;

  logic        clk;
  logic        rst;
  logic [15:0] price_in;
  logic        new_price;
  logic        buy;
  logic        sell;
  logic        sig_valid;
  logic        order_valid;
  logic        order_ready;
  logic        order_side;
  logic [15:0] order_price;
  logic [7:0]  order_qty;
  logic        long_pos;
  logic [15:0] entry_price;
  logic [31:0] realized_pnl;
  logic [7:0]  trade_cnt;
  logic        stop_hit;

  typedef struct {
    logic        side;
    logic [15:0] price;
  } expOrder_t;

  expOrder_t expQ[$];
  int        vecCount  = 0;
  int        missCount = 0;
  logic      prevValid = 1'b0;

  order_manager dut (
    .clk         (clk),
    .rst         (rst),
    .price_in    (price_in),
    .new_price   (new_price),
    .buy         (buy),
    .sell        (sell),
    .sig_valid   (sig_valid),
    .order_valid (order_valid),
    .order_ready (order_ready),
    .order_side  (order_side),
    .order_price (order_price),
    .order_qty   (order_qty),
    .long_pos    (long_pos),
    .entry_price (entry_price),
    .realized_pnl(realized_pnl),
    .trade_cnt   (trade_cnt),
    .stop_hit    (stop_hit)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs starting just after a rising edge.
  task automatic applyStimulus(input logic np, input logic [15:0] price,
                               input logic sv, input logic b, input logic s);
    new_price = np;
    price_in  = price;
    sig_valid = sv;
    buy       = b;
    sell      = s;
    @(posedge clk);
    #1;
    new_price = 1'b0;
    price_in  = 16'd0;
    sig_valid = 1'b0;
    buy       = 1'b0;
    sell      = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectOrder(input logic side, input logic [15:0] price);
    expOrder_t e;
    e.side  = side;
    e.price = price;
    expQ.push_back(e);
  endtask

  // Scoreboard monitor: checks each new order against the queue head and pops on fill.
  always @(negedge clk) begin
    expOrder_t e;
    if (!rst) begin
      prevValid = 1'b0;
    end else begin
      if (order_valid && !prevValid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_order", 32'd1, 32'd0);
        end else begin
          checkOutput("issue_side", {31'd0, order_side}, {31'd0, expQ[0].side});
          checkOutput("issue_price", {16'd0, order_price}, {16'd0, expQ[0].price});
        end
      end
      if (order_valid && order_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_fill", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("fill_side", {31'd0, order_side}, {31'd0, e.side});
          checkOutput("fill_price", {16'd0, order_price}, {16'd0, e.price});
          checkOutput("fill_qty", {24'd0, order_qty}, 32'd10);
        end
      end
      prevValid = order_valid;
    end
  end

  // Main test sequence.
  initial begin
    logic [15:0] coolPrices [4];
    coolPrices = '{16'd10300, 16'd10350, 16'd10400, 16'd10490};

    rst         = 1'b0;
    price_in    = 16'd0;
    new_price   = 1'b0;
    buy         = 1'b0;
    sell        = 1'b0;
    sig_valid   = 1'b0;
    order_ready = 1'b0;

    waitCycles(3);
    checkOutput("rst_valid", {31'd0, order_valid}, 32'd0);
    checkOutput("rst_qty", {24'd0, order_qty}, 32'd0);
    checkOutput("rst_long", {31'd0, long_pos}, 32'd0);
    checkOutput("rst_entry", {16'd0, entry_price}, 32'd0);
    checkOutput("rst_pnl", realized_pnl, 32'd0);
    checkOutput("rst_trades", {24'd0, trade_cnt}, 32'd0);
    checkOutput("rst_stop", {31'd0, stop_hit}, 32'd0);
    rst = 1'b1;
    waitCycles(1);

    $display("[TB] buy before any price");
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("no_price_buy", {31'd0, order_valid}, 32'd0);

    $display("[TB] buy fill with ready asserted early");
    order_ready = 1'b1;
    applyStimulus(1'b1, 16'd10234, 1'b0, 1'b0, 1'b0);
    expectOrder(1'b0, 16'd10234);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("buy_valid", {31'd0, order_valid}, 32'd1);
    checkOutput("buy_qty", {24'd0, order_qty}, 32'd10);
    waitCycles(1);
    checkOutput("buy_done_valid", {31'd0, order_valid}, 32'd0);
    checkOutput("buy_long", {31'd0, long_pos}, 32'd1);
    checkOutput("buy_entry", {16'd0, entry_price}, 32'd10234);
    checkOutput("buy_trades", {24'd0, trade_cnt}, 32'd1);

    $display("[TB] sell blocked by cooldown, then backpressured sell");
    order_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, coolPrices[i], 1'b1, 1'b0, 1'b1);
      checkOutput("cooldown_sell", {31'd0, order_valid}, 32'd0);
    end
    expectOrder(1'b1, 16'd10490);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("sell_valid", {31'd0, order_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      waitCycles(1);
      checkOutput("bp_valid", {31'd0, order_valid}, 32'd1);
      checkOutput("bp_price", {16'd0, order_price}, 32'd10490);
      checkOutput("bp_side", {31'd0, order_side}, 32'd1);
    end
    order_ready = 1'b1;
    waitCycles(1);
    checkOutput("sell_done_valid", {31'd0, order_valid}, 32'd0);
    checkOutput("sell_pnl", realized_pnl, 32'd2560);
    checkOutput("sell_trades", {24'd0, trade_cnt}, 32'd2);
    checkOutput("sell_long", {31'd0, long_pos}, 32'd0);
    checkOutput("sell_entry_hold", {16'd0, entry_price}, 32'd10234);

    $display("[TB] conflicting and unqualified signals while flat");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'd10790, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("flat_sell", {31'd0, order_valid}, 32'd0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b1);
    checkOutput("both_high", {31'd0, order_valid}, 32'd0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("no_sig_valid", {31'd0, order_valid}, 32'd0);

    $display("[TB] stop-loss boundary and trigger during cooldown");
    expectOrder(1'b0, 16'd10790);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("buy2_valid", {31'd0, order_valid}, 32'd1);
    waitCycles(1);
    checkOutput("buy2_entry", {16'd0, entry_price}, 32'd10790);
    checkOutput("buy2_trades", {24'd0, trade_cnt}, 32'd3);
    applyStimulus(1'b1, 16'd10590, 1'b0, 1'b0, 1'b0);
    checkOutput("stop_edge_valid", {31'd0, order_valid}, 32'd0);
    checkOutput("stop_edge_hit", {31'd0, stop_hit}, 32'd0);
    expectOrder(1'b1, 16'd10580);
    applyStimulus(1'b1, 16'd10580, 1'b0, 1'b0, 1'b0);
    checkOutput("stop_hit", {31'd0, stop_hit}, 32'd1);
    checkOutput("stop_valid", {31'd0, order_valid}, 32'd1);
    checkOutput("stop_price", {16'd0, order_price}, 32'd10580);
    waitCycles(1);
    checkOutput("stop_hit_pulse", {31'd0, stop_hit}, 32'd0);
    checkOutput("stop_done_valid", {31'd0, order_valid}, 32'd0);
    checkOutput("stop_pnl", realized_pnl, 32'd460);
    checkOutput("stop_trades", {24'd0, trade_cnt}, 32'd4);

    $display("[TB] buy signal while a sell is pending");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'd10600, 1'b0, 1'b0, 1'b0);
    end
    expectOrder(1'b0, 16'd10600);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    waitCycles(1);
    checkOutput("buy3_trades", {24'd0, trade_cnt}, 32'd5);
    order_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'd10700, 1'b0, 1'b0, 1'b0);
    end
    expectOrder(1'b1, 16'd10700);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("pend_valid", {31'd0, order_valid}, 32'd1);
    applyStimulus(1'b1, 16'd10000, 1'b1, 1'b1, 1'b0);
    checkOutput("pend_valid_hold", {31'd0, order_valid}, 32'd1);
    checkOutput("pend_side_hold", {31'd0, order_side}, 32'd1);
    checkOutput("pend_price_hold", {16'd0, order_price}, 32'd10700);
    checkOutput("pend_no_stop", {31'd0, stop_hit}, 32'd0);

    $display("[TB] reset during a pending order");
    rst = 1'b0;
    expQ.delete();
    #1;
    checkOutput("async_valid", {31'd0, order_valid}, 32'd0);
    checkOutput("async_qty", {24'd0, order_qty}, 32'd0);
    checkOutput("async_long", {31'd0, long_pos}, 32'd0);
    checkOutput("async_trades", {24'd0, trade_cnt}, 32'd0);
    checkOutput("async_pnl", realized_pnl, 32'd0);
    checkOutput("async_entry", {16'd0, entry_price}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("post_rst_no_price", {31'd0, order_valid}, 32'd0);
    order_ready = 1'b1;
    expectOrder(1'b0, 16'd10234);
    applyStimulus(1'b1, 16'd10234, 1'b1, 1'b1, 1'b0);
    checkOutput("same_cycle_price_valid", {31'd0, order_valid}, 32'd1);
    waitCycles(1);
    checkOutput("post_rst_trades", {24'd0, trade_cnt}, 32'd1);
    checkOutput("post_rst_entry", {16'd0, entry_price}, 32'd10234);
    checkOutput("post_rst_long", {31'd0, long_pos}, 32'd1);

    waitCycles(2);
    checkOutput("scoreboard_empty", expQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
